// File: rtl/sequencer_pkg.sv
// sequencer_pkg: command word layout and fetcher state encoding shared with the music sequencer.
package sequencer_pkg;
  localparam int CMD_W = 12;
  localparam int CMD_DELAY_BIT = 11;
  localparam int CMD_START_BIT = 10;
  localparam int NOTE_W = 7;
  localparam int DUR_W = 11;
  localparam logic [CMD_W-1:0] CMD_SILENCE = 12'h000;
  localparam logic [CMD_W-1:0] END_CMD = 12'h800;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    NEXT   = 3'd3,
    ARM    = 3'd4,
    WAIT   = 3'd5,
    DONE   = 3'd6
  } fetch_state_t;
endpackage

// File: rtl/song_fetcher.sv
// song_fetcher: walks a synchronous song ROM and paces commands into the sequencer.
// Define SONG_LOOP_EN to restart at address 0 on the end marker instead of stopping in DONE.
module song_fetcher
  import sequencer_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int ARM_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              play,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [CMD_W-1:0]  rom_data,
  input  logic              busy,
  output logic [CMD_W-1:0]  command,
  output logic              running,
  output logic              done
);
  localparam int CW = $clog2(ARM_CYCLES) + 1;
  localparam logic [CW-1:0] ARM_LAST = CW'(ARM_CYCLES - 1);
  fetch_state_t      r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [CMD_W-1:0]  r_cmd;
  logic [CW-1:0]     r_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_cmd   <= CMD_SILENCE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: if (play) r_state <= FETCH;
        FETCH: r_state <= DECODE;
        DECODE:
          if (rom_data == END_CMD) begin
`ifdef SONG_LOOP_EN
            r_addr  <= '0;
            r_state <= NEXT;
`else
            r_cmd   <= CMD_SILENCE;
            r_state <= DONE;
`endif
          end else if (rom_data[CMD_DELAY_BIT]) begin
            r_cmd   <= rom_data;
            r_cnt   <= '0;
            r_state <= ARM;
          end else begin
            r_cmd   <= rom_data;
            r_addr  <= r_addr + 1'b1;
            r_state <= NEXT;
          end
        NEXT:
          if (play) r_state <= FETCH;
          else begin
            r_cmd   <= CMD_SILENCE;
            r_state <= IDLE;
          end
        // a delay the sequencer never acknowledges is treated as already finished
        ARM:
          if (busy) r_state <= WAIT;
          else if (r_cnt == ARM_LAST) begin
            r_addr  <= r_addr + 1'b1;
            r_state <= NEXT;
          end else r_cnt <= r_cnt + 1'b1;
        WAIT:
          if (!busy) begin
            r_addr  <= r_addr + 1'b1;
            r_state <= NEXT;
          end
        default: r_state <= r_state;
      endcase
    end
  assign rom_addr = r_addr;
  assign command  = r_cmd;
  assign running  = (r_state == IDLE || r_state == DONE) ? 1'b0 : 1'b1;
  assign done     = (r_state == DONE);
endmodule
